uart_rx_block: RTL and testbench
================================

Name: uart_rx_block

Overview:
- Byte-wide UART receiver: 8N1 frames, LSB first, idle-high line. Companion to the transmit block on the same serial link.
- Presents the same CONTROL/DATA/STATUS byte-register style as the transmitter, so the CPU bus glue maps both identically.
- Oversamples LINE_IN, validates start and stop bits, and holds one received byte until the CPU acknowledges it.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 9600, serial bit rate.
- OVERSAMPLE, 16, sample ticks per bit period; must be even and at least 8.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset, asynchronous, active-low (0 = reset).
- LINE_IN  in  1  serial input, asynchronous to CLK, idle high.
- CONTROL  in  8  command: NOP=0x00, ACK=0xFF (consume byte, clear flags).
- DATA  out  8  last received byte.
- STATUS  out  8  bit0 VALID, bit1 FERR (framing error), bit2 OVR (overrun), bit3 BUSY (frame in progress), bits7:4 = 0.

Behaviour:
- Reset (RST=0, asynchronous): DATA=0x00, STATUS=0x00, state=IDLE, synchronizer flops=1, all counters=0.
- LINE_IN passes through a 2-flop synchronizer. All decisions use the synchronized value.
- Sample tick divisor = CLK_FREQ/(BAUD*OVERSAMPLE), integer truncation (defaults give 325). The tick counter is held cleared while in IDLE, so tick phase aligns to the detected start edge.
- States:
  - IDLE: a 1->0 transition on the synced line -> START; sub-count=0; BUSY=1.
  - START: on tick OVERSAMPLE/2 (mid start bit), sample the line.
    - Line 0 -> DATA_BITS, bit index=0.
    - Line 1 -> false start; return to IDLE, BUSY=0, no flag change.
  - DATA_BITS: every OVERSAMPLE ticks, sample into shift register position [bit index]. After bit 7 -> STOP.
  - STOP: after OVERSAMPLE ticks, sample the stop bit.
    - Line 1: DATA<=shift register, VALID=1, FERR=0 -> IDLE.
    - Line 0: DATA<=shift register, VALID=1, FERR=1 -> WAIT_HIGH.
  - WAIT_HIGH (break or framing recovery): stay until the synced line is 1, then -> IDLE. BUSY=1 throughout.
- BUSY=1 in every state except IDLE.
- Latency: DATA and VALID update on the CLK edge following the stop-bit sample tick. Next-frame start detection is armed the cycle after entering IDLE.
- ACK, and ACK repeated: CONTROL==ACK clears VALID, FERR and OVR on the next edge; DATA is retained. Level-sensitive: ACK held for many cycles is harmless.
- Other CONTROL values: all values other than 0xFF behave as NOP.
- Overrun: a frame completing while VALID=1 sets OVR=1, overwrites DATA and updates FERR for the new frame.
- Simultaneous completion and ACK in the same cycle: completion wins. VALID=1, DATA=new byte, OVR=0, FERR from the new frame.
- Reset mid-frame: immediate abort with all outputs at reset values. No partial byte is ever presented.
- Bit index is 3 bits wide; the sub-tick counter is sized to clog2(OVERSAMPLE).

Decomposition:
- Shared package (uart_pkg): state encodings (IDLE, START, DATA_BITS, STOP, WAIT_HIGH), command codes NOP/ACK, STATUS bit positions. The transmitter's RDY/BSY/SND codes move here as well.
- One sub-module, uart_rx_tick: parameterized divisor counter with a synchronous clear input, emitting a one-CLK pulse per sample tick.

Test Plan:
- Clean frame: send 0xA5 at 9600 baud (5208 CLK per bit) -> DATA=0xA5 and STATUS=0x01 within 1 bit time of the stop-bit midpoint; ACK -> STATUS=0x00, DATA stays 0xA5.
- False start: 2000-CLK low glitch (shorter than half a bit period of 2604 CLK), line high otherwise -> STATUS returns to 0x00, DATA unchanged, no VALID.
- Framing error: send 0x3C with a 0 stop bit, then hold low for 20 bit times -> STATUS=0x0B (VALID|FERR|BUSY) while low; after the line rises -> 0x03; a following clean 0x55 frame is received correctly.
- Overrun: send 0x11 then 0x22 with no ACK -> DATA=0x22, STATUS=0x05; ACK -> 0x00.
- Completion/ACK collision: with VALID=1 (byte 0x11), assert ACK exactly on the completion cycle of 0x77 -> DATA=0x77, STATUS=0x01 (no OVR).
- Async reset mid-frame: drop RST at bit 4 of 0xF0 -> DATA=0x00 and STATUS=0x00 immediately; release RST; next frame 0x81 -> DATA=0x81, STATUS=0x01.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit and receive blocks.
// Holds the receiver state encoding, the CONTROL command codes, the STATUS
// bit positions and the sample-tick divisor helper. The transmitter's
// RDY/BSY/SND codes live here too so both blocks map onto the bus alike.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA_BITS = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } rx_state_t;

  // CONTROL command codes (shared by transmitter and receiver)
  localparam logic [7:0] CMD_NOP = 8'h00;
  localparam logic [7:0] CMD_ACK = 8'hFF;

  // Transmitter command / status codes
  localparam logic [7:0] TX_CMD_SND  = 8'h01;
  localparam logic [7:0] TX_STAT_RDY = 8'h00;
  localparam logic [7:0] TX_STAT_BSY = 8'h01;

  // Receiver STATUS bit positions; bits 7:4 read as zero
  localparam int STAT_VALID = 0;
  localparam int STAT_FERR  = 1;
  localparam int STAT_OVR   = 2;
  localparam int STAT_BUSY  = 3;

  // CLK cycles per sample tick, truncated
  function automatic int unsigned tick_div(input int unsigned clk_freq,
                                           input int unsigned baud,
                                           input int unsigned oversample);
    return clk_freq / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_rx_tick.sv
// Sample-tick generator for the UART receiver.
// Ports:
//   CLK  - system clock
//   RST  - asynchronous active-low reset
//   clr  - synchronous clear; holds the counter at zero and masks the tick
//   tick - one-CLK pulse every DIV cycles while clr is low
module uart_rx_tick #(
  parameter int unsigned DIV = 325
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt <= '0;
    end else if (clr || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/uart_rx_block.sv
// Byte-wide 8N1 UART receiver with a CONTROL/DATA/STATUS register face.
// Ports:
//   CLK     - system clock, rising edge
//   RST     - asynchronous active-low reset
//   LINE_IN - serial input, asynchronous, idle high
//   CONTROL - command byte: 0xFF = ACK (clear VALID/FERR/OVR), others = NOP
//   DATA    - last received byte
//   STATUS  - {4'b0, BUSY, OVR, FERR, VALID}
//
// state        | meaning
// -------------+------------------------------------------------------
// ST_IDLE      | line idle, waiting for a 1->0 edge; tick counter held
// ST_START     | checking the start bit at its midpoint
// ST_DATA_BITS | sampling 8 data bits, LSB first, one per bit period
// ST_STOP      | sampling the stop bit, then publishing the byte
// ST_WAIT_HIGH | stop bit was low (break/framing); wait for line high
module uart_rx_block
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       LINE_IN,
  input  logic [7:0] CONTROL,
  output logic [7:0] DATA,
  output logic [7:0] STATUS
);

  localparam int unsigned DIV = tick_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int unsigned SW  = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] SUB_HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SUB_LAST = SW'(OVERSAMPLE - 1);

  rx_state_t     state, state_nxt;
  logic          sync_1, line_s, line_d;
  logic          tick;
  logic [SW-1:0] sub_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic [7:0]    data_q;
  logic          valid_q, ferr_q, ovr_q;
  logic          sub_clr, sub_inc, smp_bit, frame_done;
  logic          ack;

  assign ack = (CONTROL == CMD_ACK);

  // Two-flop synchronizer plus one delayed copy for edge detection
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_1 <= 1'b1;
      line_s <= 1'b1;
      line_d <= 1'b1;
    end else begin
      sync_1 <= LINE_IN;
      line_s <= sync_1;
      line_d <= line_s;
    end
  end

  // Cleared throughout IDLE so tick phase starts at the detected edge
  uart_rx_tick #(.DIV(DIV)) u_tick (
    .CLK  (CLK),
    .RST  (RST),
    .clr  (state == ST_IDLE),
    .tick (tick)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    sub_clr    = 1'b0;
    sub_inc    = 1'b0;
    smp_bit    = 1'b0;
    frame_done = 1'b0;
    case (state)
      ST_IDLE: begin
        sub_clr = 1'b1;
        if (line_d && !line_s) begin
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          if (sub_cnt == SUB_HALF) begin
            sub_clr   = 1'b1;
            state_nxt = line_s ? ST_IDLE : ST_DATA_BITS;
          end else begin
            sub_inc = 1'b1;
          end
        end
      end
      ST_DATA_BITS: begin
        if (tick) begin
          if (sub_cnt == SUB_LAST) begin
            sub_clr = 1'b1;
            smp_bit = 1'b1;
            if (bit_idx == 3'd7) begin
              state_nxt = ST_STOP;
            end
          end else begin
            sub_inc = 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (sub_cnt == SUB_LAST) begin
            sub_clr    = 1'b1;
            frame_done = 1'b1;
            state_nxt  = line_s ? ST_IDLE : ST_WAIT_HIGH;
          end else begin
            sub_inc = 1'b1;
          end
        end
      end
      ST_WAIT_HIGH: begin
        if (line_s) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sub_cnt   <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      if (sub_clr) begin
        sub_cnt <= '0;
      end else if (sub_inc) begin
        sub_cnt <= sub_cnt + 1'b1;
      end

      if (state == ST_IDLE) begin
        bit_idx <= '0;
      end else if (smp_bit) begin
        bit_idx <= bit_idx + 1'b1;
      end

      if (smp_bit) begin
        shift_reg[bit_idx] <= line_s;
      end

      // Completion beats a same-cycle ACK; the ACK only suppresses OVR
      if (frame_done) begin
        data_q  <= shift_reg;
        valid_q <= 1'b1;
        ferr_q  <= !line_s;
        ovr_q   <= valid_q && !ack;
      end else if (ack) begin
        valid_q <= 1'b0;
        ferr_q  <= 1'b0;
        ovr_q   <= 1'b0;
      end
    end
  end

  assign DATA = data_q;

  always_comb begin
    STATUS             = 8'h00;
    STATUS[STAT_VALID] = valid_q;
    STATUS[STAT_FERR]  = ferr_q;
    STATUS[STAT_OVR]   = ovr_q;
    STATUS[STAT_BUSY]  = (state != ST_IDLE);
  end

endmodule

// File: tb/tb_uart_rx_block.sv
module tb_uart_rx_block;

  // Scaled-down bit rate keeps the run short: 10 CLK per tick, 160 per bit
  localparam int CLK_FREQ = 1600000;
  localparam int BAUD     = 10000;
  localparam int OS       = 16;
  localparam int DIVV     = CLK_FREQ / (BAUD * OS);
  localparam int BIT      = DIVV * OS;
  // Frame-relative cycle whose CONTROL value is seen on the completion edge:
  // 2 sync flops + edge detect, then mid start bit + 9 full bit periods of ticks
  localparam int DONE_C   = 3 + DIVV * (OS / 2 + 9 * OS) - 1;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       LINE_IN = 1'b1;
  logic [7:0] CONTROL = 8'h00;
  logic [7:0] DATA;
  logic [7:0] STATUS;

  int checks = 0;
  int failures = 0;

  // Reference model of the register face
  logic [7:0] m_data = 8'h00;
  bit m_valid = 0, m_ferr = 0, m_ovr = 0, m_busy = 0;

  always #5 CLK = ~CLK;

  uart_rx_block #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OS)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .LINE_IN(LINE_IN),
    .CONTROL(CONTROL),
    .DATA   (DATA),
    .STATUS (STATUS)
  );

  function automatic logic [7:0] m_status();
    return {4'b0000, m_busy, m_ovr, m_ferr, m_valid};
  endfunction

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    check8({tag, "_data"}, DATA, m_data);
    check8({tag, "_status"}, STATUS, m_status());
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_ack(input int n);
    CONTROL = 8'hFF;
    clks(n);
    CONTROL = 8'h00;
    m_valid = 0;
    m_ferr  = 0;
    m_ovr   = 0;
  endtask

  // Drives one full frame; ack_at >= 0 pulses ACK on that frame-relative cycle.
  // The line is left at the stop-bit level.
  task automatic send_frame(input logic [7:0] b, input bit stop, input int ack_at,
                            input logic [7:0] ctrl_idle);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int c = 0; c < 10 * BIT; c++) begin
      LINE_IN = fr[c / BIT];
      CONTROL = (c == ack_at) ? 8'hFF : ctrl_idle;
      clks(1);
    end
    CONTROL = 8'h00;
    m_data  = b;
    m_ovr   = (ack_at == DONE_C) ? 1'b0 : m_valid;
    m_valid = 1;
    m_ferr  = !stop;
    m_busy  = !stop;
  endtask

  initial begin
    logic [9:0] fr;
    logic [7:0] rb;
    bit         rs;

    // Reset state
    #1;
    check_regs("reset");
    clks(3);
    RST = 1'b1;
    clks(5);
    check_regs("idle");

    // Clean frame, then ACK (single and long-held)
    send_frame(8'hA5, 1'b1, -1, 8'h00);
    clks(BIT);
    check_regs("clean_a5");
    do_ack(1);
    clks(2);
    check_regs("ack_a5");
    send_frame(8'h3E, 1'b1, -1, 8'h00);
    clks(BIT);
    do_ack(50);
    clks(2);
    check_regs("ack_held");

    // False start: low glitch shorter than half a bit
    LINE_IN = 1'b0;
    clks(40);
    m_busy = 1;
    check_regs("glitch_busy");
    clks(20);
    LINE_IN = 1'b1;
    clks(2 * BIT);
    m_busy = 0;
    check_regs("false_start");

    // Framing error with the line held low, then recovery
    send_frame(8'h3C, 1'b0, -1, 8'h00);
    clks(20 * BIT);
    check_regs("ferr_low");
    LINE_IN = 1'b1;
    clks(10);
    m_busy = 0;
    check_regs("ferr_high");
    do_ack(1);
    clks(BIT);
    send_frame(8'h55, 1'b1, -1, 8'h00);
    clks(BIT);
    check_regs("after_ferr_55");
    do_ack(1);

    // Overrun
    clks(BIT);
    send_frame(8'h11, 1'b1, -1, 8'h00);
    clks(BIT);
    send_frame(8'h22, 1'b1, -1, 8'h00);
    clks(BIT);
    check_regs("overrun");
    do_ack(1);
    clks(2);
    check_regs("overrun_ack");

    // Completion and ACK on the same edge
    send_frame(8'h11, 1'b1, -1, 8'h00);
    clks(BIT);
    send_frame(8'h77, 1'b1, DONE_C, 8'h00);
    clks(BIT);
    check_regs("collision");
    do_ack(1);
    clks(BIT);

    // Async reset in the middle of bit 4
    fr = {1'b1, 8'hF0, 1'b0};
    for (int c = 0; c < 5 * BIT + BIT / 2; c++) begin
      LINE_IN = fr[c / BIT];
      clks(1);
    end
    RST = 1'b0;
    #1;
    m_data = 8'h00; m_valid = 0; m_ferr = 0; m_ovr = 0; m_busy = 0;
    check_regs("mid_reset");
    clks(5);
    LINE_IN = 1'b1;
    RST = 1'b1;
    clks(5);
    send_frame(8'h81, 1'b1, -1, 8'h00);
    clks(BIT);
    check_regs("post_reset_81");

    // Randomized frames: random bytes, stop bits, NOP codes and ACK usage
    for (int i = 0; i < 8; i++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) begin
        do_ack($urandom_range(1, 5));
      end
      clks(BIT);
      send_frame(rb, rs, -1, 8'($urandom_range(0, 254)));
      LINE_IN = 1'b1;
      clks(BIT + $urandom_range(0, 50));
      m_busy = 0;
      check_regs($sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
